ibex_fetch_redirect: RTL and testbench

Instruction-fetch address sequencer that sits directly upstream of `ibex_core`. It generates sequential fetch requests and applies the debug redirects: to `DmHaltAddr` on a halt request, and to `DmExceptionAddr` on an exception while in debug mode. It also saves and restores the debug PC. `rv_core_ibex` instantiates it and passes the same `DmExceptionAddr` value it forwards to the core.

---
 rtl/ibex_fetch_redirect.sv | 125 ++++++++++++
 tb/tb_ibex_fetch_redirect.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_redirect.sv
// Fetch address sequencer for ibex_core: sequential fetch requests plus
// debug halt / debug-exception / dret redirects with saved debug PC.
module ibex_fetch_redirect #(
  parameter logic [31:0] BootAddr        = 32'h0000_0080,
  parameter logic [31:0] DmHaltAddr      = 32'd10,
  parameter logic [31:0] DmExceptionAddr = 32'd12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_en_i,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        debug_req_i,
  input  logic        exc_i,
  input  logic        dret_i,
  output logic [31:0] dpc_o,
  output logic        debug_mode_o,
  output logic        redirect_o
);

  localparam int unsigned AddrW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DEBUG = 2'd2
  } state_e;

  // Encoding doubles as priority: larger value wins.
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_HALT = 2'd1,
    EV_DRET = 2'd2,
    EV_EXC  = 2'd3
  } event_e;

  state_e             state_q, state_d;
  event_e             pend_q, pend_d;
  event_e             new_ev, eff_ev;
  logic               req_q, req_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [AddrW-1:0]   dpc_q, dpc_d;
  logic               redirect_q, redirect_d;
  logic               stall, handshake;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pend_q     <= EV_NONE;
      req_q      <= 1'b0;
      addr_q     <= BootAddr;
      dpc_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      dpc_q      <= dpc_d;
      redirect_q <= redirect_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    req_d      = req_q;
    addr_d     = addr_q;
    dpc_d      = dpc_q;
    redirect_d = 1'b0;
    new_ev     = EV_NONE;

    stall     = req_q & ~gnt_i;
    handshake = req_q & gnt_i;

    // Qualify incoming events against the current state.
    case (state_q)
      RUN: begin
        if (debug_req_i) new_ev = EV_HALT;
      end
      DEBUG: begin
        if (exc_i)       new_ev = EV_EXC;
        else if (dret_i) new_ev = EV_DRET;
      end
      default: new_ev = EV_NONE;
    endcase

    eff_ev = (new_ev > pend_q) ? new_ev : pend_q;

    if (stall) begin
      pend_d = eff_ev;
    end else begin
      pend_d = EV_NONE;
      if (handshake) addr_d = addr_q + AddrW'(4);
      case (eff_ev)
        EV_HALT: begin
          dpc_d      = addr_d;
          addr_d     = DmHaltAddr;
          state_d    = DEBUG;
          redirect_d = 1'b1;
        end
        EV_EXC: begin
          addr_d     = DmExceptionAddr;
          redirect_d = 1'b1;
        end
        EV_DRET: begin
          addr_d     = dpc_q;
          state_d    = RUN;
          redirect_d = 1'b1;
        end
        default: ;
      endcase
      if (state_q == IDLE && fetch_en_i) state_d = RUN;
      req_d = (state_d != IDLE) & fetch_en_i;
    end
  end

  assign req_o        = req_q;
  assign addr_o       = addr_q;
  assign dpc_o        = dpc_q;
  assign debug_mode_o = (state_q == DEBUG);
  assign redirect_o   = redirect_q;

endmodule

// File: tb/tb_ibex_fetch_redirect.sv
// Self-checking bench for ibex_fetch_redirect: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_ibex_fetch_redirect;

  localparam logic [31:0] BOOT = 32'h0000_0080;
  localparam logic [31:0] HALT = 32'd10;
  localparam logic [31:0] EXCA = 32'hFFFF_FFF8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        gnt_i = 1'b0;
  logic        debug_req_i = 1'b0;
  logic        exc_i = 1'b0;
  logic        dret_i = 1'b0;
  logic        req_o;
  logic [31:0] addr_o;
  logic [31:0] dpc_o;
  logic        debug_mode_o;
  logic        redirect_o;

  ibex_fetch_redirect #(
    .BootAddr       (BOOT),
    .DmHaltAddr     (HALT),
    .DmExceptionAddr(EXCA)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fetch_en_i  (fetch_en_i),
    .req_o       (req_o),
    .addr_o      (addr_o),
    .gnt_i       (gnt_i),
    .debug_req_i (debug_req_i),
    .exc_i       (exc_i),
    .dret_i      (dret_i),
    .dpc_o       (dpc_o),
    .debug_mode_o(debug_mode_o),
    .redirect_o  (redirect_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode 0=idle 1=run 2=debug; pend is event rank
  // (0 none, 1 halt, 2 dret, 3 exception).
  int          m_mode = 0;
  int          m_pend = 0;
  bit          m_valid = 0;
  logic        m_req = 0;
  logic [31:0] m_addr = BOOT;
  logic [31:0] m_dpc = 0;
  logic        m_redir = 0;

  always @(posedge clk_i) begin
    int          ev;
    logic [31:0] next_pc;
    if (rst_i) begin
      m_valid = 1; m_mode = 0; m_pend = 0; m_req = 0;
      m_addr = BOOT; m_dpc = 0; m_redir = 0;
    end else begin
      ev = 0;
      if (m_mode == 1 && debug_req_i) ev = 1;
      if (m_mode == 2 && dret_i) ev = 2;
      if (m_mode == 2 && exc_i) ev = 3;
      if (ev > m_pend) m_pend = ev;
      m_redir = 0;
      if (!(m_req && !gnt_i)) begin
        next_pc = (m_req && gnt_i) ? m_addr + 32'd4 : m_addr;
        m_addr  = next_pc;
        if (m_pend == 1) begin m_dpc = next_pc; m_addr = HALT; m_mode = 2; end
        if (m_pend == 2) begin m_addr = m_dpc; m_mode = 1; end
        if (m_pend == 3) m_addr = EXCA;
        m_redir = (m_pend != 0);
        m_pend  = 0;
        if (m_mode == 0 && fetch_en_i) m_mode = 1;
        m_req = (m_mode != 0) && fetch_en_i;
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_valid) begin
      check("req",      32'(req_o),        32'(m_req));
      check("addr",     addr_o,            m_addr);
      check("dpc",      dpc_o,             m_dpc);
      check("dbg_mode", 32'(debug_mode_o), 32'(m_mode == 2));
      check("redirect", 32'(redirect_o),   32'(m_redir));
    end
  end

  task automatic cyc(input logic r, input logic fe, input logic g,
                     input logic dq, input logic ex, input logic dr);
    rst_i = r; fetch_en_i = fe; gnt_i = g;
    debug_req_i = dq; exc_i = ex; dret_i = dr;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_req", 32'(req_o), 32'd0);
    check("rst_addr", addr_o, BOOT);
    check("rst_dpc", dpc_o, 32'd0);
    check("rst_redir", 32'(redirect_o), 32'd0);

    cyc(0, 1, 0, 0, 0, 0);
    check("first_req", 32'(req_o), 32'd1);
    check("first_addr", addr_o, 32'h80);
    cyc(0, 1, 1, 0, 0, 0);
    check("seq_addr", addr_o, 32'h84);

    // Halt arrives during a stall and waits for the grant.
    cyc(0, 1, 0, 1, 0, 0);
    check("stall_addr1", addr_o, 32'h84);
    check("stall_redir", 32'(redirect_o), 32'd0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("stall_addr3", addr_o, 32'h84);
    check("stall_dbg", 32'(debug_mode_o), 32'd0);
    cyc(0, 1, 1, 0, 0, 0);
    check("halt_addr", addr_o, 32'd10);
    check("halt_redir", 32'(redirect_o), 32'd1);
    check("halt_dpc", dpc_o, 32'h88);
    check("halt_dbg", 32'(debug_mode_o), 32'd1);

    cyc(0, 1, 1, 0, 1, 0);
    check("exc_addr", addr_o, 32'hFFFF_FFF8);
    check("exc_dpc", dpc_o, 32'h88);
    cyc(0, 1, 1, 0, 0, 1);
    check("dret_addr", addr_o, 32'h88);
    check("dret_dbg", 32'(debug_mode_o), 32'd0);

    cyc(0, 1, 1, 1, 0, 0);
    check("halt2_dpc", dpc_o, 32'h8C);
    cyc(0, 1, 1, 0, 1, 1);
    check("prio_addr", addr_o, 32'hFFFF_FFF8);
    check("prio_dbg", 32'(debug_mode_o), 32'd1);
    cyc(0, 1, 1, 0, 0, 0);
    check("pre_wrap", addr_o, 32'hFFFF_FFFC);
    cyc(0, 1, 1, 0, 0, 0);
    check("wrap", addr_o, 32'h0);
    cyc(0, 1, 1, 0, 0, 1);
    check("dret2_addr", addr_o, 32'h8C);
    cyc(0, 1, 1, 0, 1, 0);
    check("run_exc_addr", addr_o, 32'h90);
    check("run_exc_redir", 32'(redirect_o), 32'd0);

    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
    end

    // Reset while stalled with a halt pending.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    check("rst2_req", 32'(req_o), 32'd0);
    check("rst2_addr", addr_o, BOOT);
    check("rst2_dbg", 32'(debug_mode_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 0, 0);
      check("post_rst_redir", 32'(redirect_o), 32'd0);
      check("post_rst_addr", addr_o, BOOT);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
